// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//
// Bundles the instruction fields and ALU flags coming from the datapath together
// with every control output of the multicycle control unit.
//
//   Cond[3:0]       instruction bits [31:28]
//   Op[1:0]         instruction bits [27:26]
//   Funct[5:0]      instruction bits [25:20]
//   Rd[3:0]         instruction bits [15:12]
//   ALUFlags[3:0]   {N,Z,C,V} from the ALU for the current cycle
//   PCWrite, MemWrite, RegWrite, IRWrite   write enables
//   AdrSrc, ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUControl[1:0],
//   ImmSrc[1:0], RegSrc[1:0]               datapath selects
//   Flags[3:0]      registered NZCV
//   State[3:0]      current FSM state
//
// Modports:
//   master - datapath side: drives instruction fields and ALU flags
//   slave  - control unit side: drives all control outputs
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;

    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] Flags;
    logic [3:0] State;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for the multicycle ARM-subset processor. Sequences the shared
// datapath (one ALU, one unified memory port, register file) through
// fetch / decode / execute / memory / writeback, owns the NZCV flags register
// and the condition check that aborts a failed instruction at decode.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of multicycle_ctrl_if (instruction fields, ALU
//          flags in; write enables, mux selects, Flags, State out)
//
// State table:
//   state  | meaning
//   FETCH  | load IR from mem[PC], PC <= PC+4
//   DECODE | read registers, check condition, compute PC+8
//   MEMADR | compute load/store address (base + imm)
//   MEMRD  | read memory at computed address
//   MEMWB  | write loaded data to Rd
//   MEMWR  | write register B to memory
//   EXECR  | ALU op with register second operand
//   EXECI  | ALU op with immediate second operand
//   ALUWB  | write ALU result to Rd
//   BRANCH | PC <= PC+8 + offset
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags_q;

    logic       cond_ex;
    logic [1:0] dp_op;
    logic       dp_ok;
    logic       rd_is_pc;
    logic       flag_ld;

    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;

    // ------------------------------------------------------------------
    // Data-processing decode from Funct[4:1]. Unsupported opcodes still
    // walk through EXEC/ALUWB as an ADD, but never write anything back.
    // ------------------------------------------------------------------
    always_comb begin
        dp_op = ALU_ADD;
        dp_ok = 1'b1;
        case (bus.Funct[4:1])
            4'b0100: dp_op = ALU_ADD;
            4'b0010: dp_op = ALU_SUB;
            4'b0000: dp_op = ALU_AND;
            4'b1100: dp_op = ALU_ORR;
            default: dp_ok = 1'b0;
        endcase
    end

    assign rd_is_pc = (bus.Rd == 4'd15);

    // ------------------------------------------------------------------
    // Condition check against the registered flags.
    // ------------------------------------------------------------------
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (bus.Cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = ~z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = ~c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = ~n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = ~v;
            4'h8: cond_ex = c & ~z;
            4'h9: cond_ex = ~(c & ~z);
            4'hA: cond_ex = (n == v);
            4'hB: cond_ex = (n != v);
            4'hC: cond_ex = ~z & (n == v);
            4'hD: cond_ex = ~(~z & (n == v));
            4'hE: cond_ex = 1'b1;
            4'hF: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Encodings 10-15 fall into the default arm and
    // recover to FETCH.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (bus.Op)
                        2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = FETCH;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs (PCWrite/RegWrite in writeback also look at Rd and
    // the decoded op, which are stable for the whole instruction).
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                pc_write   = rd_is_pc;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_b   = SRCB_REG;
                alu_control = dp_op;
            end
            EXECI: begin
                alu_src_b   = SRCB_IMM;
                alu_control = dp_op;
            end
            ALUWB: begin
                reg_write = dp_ok;
                pc_write  = dp_ok & rd_is_pc;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // NZCV register. Loads on the edge leaving EXECR/EXECI for a
    // supported op with the S bit; logical ops keep C and V.
    // ------------------------------------------------------------------
    assign flag_ld = ((state_q == EXECR) || (state_q == EXECI)) &&
                     bus.Funct[0] && dp_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (flag_ld) begin
            if ((dp_op == ALU_ADD) || (dp_op == ALU_SUB)) begin
                flags_q <= bus.ALUFlags;
            end else begin
                flags_q[3:2] <= bus.ALUFlags[3:2];
            end
        end
    end

    // Reset forces FETCH, so the selects already show FETCH values; the
    // write enables are additionally gated so nothing is written while
    // rst_n is low.
    assign bus.PCWrite    = pc_write  & rst_n;
    assign bus.MemWrite   = mem_write & rst_n;
    assign bus.RegWrite   = reg_write & rst_n;
    assign bus.IRWrite    = ir_write  & rst_n;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {(bus.Op == 2'b01) & ~bus.Funct[0], (bus.Op == 2'b10)};
    assign bus.Flags      = flags_q;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluctl;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [3:0] flags;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q[$];
    logic [3:0] m_flags = 4'b0000;   // model NZCV

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.state     = bus.State;
        o.pcw       = bus.PCWrite;
        o.memw      = bus.MemWrite;
        o.regw      = bus.RegWrite;
        o.irw       = bus.IRWrite;
        o.adrsrc    = bus.AdrSrc;
        o.resultsrc = bus.ResultSrc;
        o.alusrca   = bus.ALUSrcA;
        o.alusrcb   = bus.ALUSrcB;
        o.aluctl    = bus.ALUControl;
        o.immsrc    = bus.ImmSrc;
        o.regsrc    = bus.RegSrc;
        o.flags     = bus.Flags;
        return o;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, ge;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        ge = (n == v);
        case (cond)
            0: return z;           1: return !z;
            2: return c;           3: return !c;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return c && !z;     9: return !(c && !z);
            10: return ge;         11: return !ge;
            12: return !z && ge;   13: return !(!z && ge);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // mnemonic code 0=ADD 1=SUB 2=AND 3=ORR, -1 = unsupported
    function automatic int alu_code(input logic [5:0] funct);
        case (funct[4:1])
            4'd4:  return 0;
            4'd2:  return 1;
            4'd0:  return 2;
            4'd12: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic obs_t exp_ctl(input int s, input logic [1:0] op, input logic [5:0] funct,
                                     input logic [3:0] rd, input logic [3:0] flags);
        obs_t e;
        int   code;
        code = alu_code(funct);
        e = '0;
        e.state  = 4'(s);
        e.immsrc = op;
        e.regsrc = {(op == 2'd1) && !funct[0], op == 2'd2};
        e.flags  = flags;
        case (s)
            0: begin e.irw = 1; e.pcw = 1; e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; end
            1: begin e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; end
            2: e.alusrcb = 1;
            3: e.adrsrc = 1;
            4: begin e.resultsrc = 1; e.regw = 1; e.pcw = (rd == 15); end
            5: begin e.adrsrc = 1; e.memw = 1; end
            6: e.aluctl = (code < 0) ? 2'd0 : 2'(code);
            7: begin e.alusrcb = 1; e.aluctl = (code < 0) ? 2'd0 : 2'(code); end
            8: begin e.regw = (code >= 0); e.pcw = (code >= 0) && (rd == 15); end
            9: begin e.alusrcb = 1; e.resultsrc = 2; e.pcw = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the
    // next FETCH.
    task automatic issue(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] af);
        int         st[$];
        int         code;
        logic [3:0] nf;
        logic [3:0] cur;
        bit         pass;
        pass = cond_pass(cond, m_flags);
        code = alu_code(funct);
        st = '{0, 1};
        if (pass) begin
            case (op)
                2'd0: begin st.push_back(funct[5] ? 7 : 6); st.push_back(8); end
                2'd1: begin
                    st.push_back(2);
                    if (funct[0]) begin st.push_back(3); st.push_back(4); end
                    else st.push_back(5);
                end
                2'd2: st.push_back(9);
                default: ;
            endcase
        end
        nf = m_flags;
        if (pass && op == 2'd0 && funct[0] && code >= 0)
            nf = (code <= 1) ? af : {af[3:2], m_flags[1:0]};
        cur = m_flags;
        foreach (st[i]) begin
            exp_q.push_back(exp_ctl(st[i], op, funct, rd, cur));
            if (st[i] == 6 || st[i] == 7) cur = nf;
        end
        bus.Cond  = cond;
        bus.Op    = op;
        bus.Funct = funct;
        bus.Rd    = rd;
        foreach (st[i]) begin
            bus.ALUFlags = (st[i] == 6 || st[i] == 7) ? af : 4'($urandom);
            @(posedge clk);
            #1;
        end
        m_flags = nf;
    endtask

    task automatic issue_random();
        logic [3:0] cond, rd, f41;
        logic [5:0] funct;
        cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        case ($urandom_range(0, 4))
            0: f41 = 4'd4;
            1: f41 = 4'd2;
            2: f41 = 4'd0;
            3: f41 = 4'd12;
            default: f41 = 4'($urandom);
        endcase
        funct = {1'($urandom), f41, 1'($urandom)};
        rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
        issue(cond, 2'($urandom), funct, rd, 4'($urandom));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = observe();
                check($sformatf("trace_state%0d", e.state), 32'(a), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        obs_t rexp;
        bit   reached;
        rst_n = 1'b0;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0; bus.ALUFlags = 4'hF;
        #12;
        // reset state: FETCH selects, no write enables, flags clear
        rexp = exp_ctl(0, 2'b00, 6'b0, 4'd0, 4'b0000);
        rexp.pcw = 0; rexp.irw = 0;
        check("reset_obs", 32'(observe()), 32'(rexp));
        check("reset_state", 32'(bus.State), 32'd0);
        check("reset_pcwrite", 32'(bus.PCWrite), 32'd0);
        check("reset_flags", 32'(bus.Flags), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // ADD AL immediate -> 0,1,7,8
        issue(4'hE, 2'b00, 6'b101000, 4'd3, 4'b1111);
        check("add_no_flag_update", 32'(bus.Flags), 32'd0);
        // SUBS register with 0110
        issue(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0110);
        check("subs_flags", 32'(bus.Flags), 32'b0110);
        // EQ executes, NE aborts
        issue(4'h0, 2'b00, 6'b001000, 4'd4, 4'b0000);
        issue(4'h1, 2'b00, 6'b001000, 4'd4, 4'b0000);
        // ANDS: C,V hold
        issue(4'hE, 2'b00, 6'b000001, 4'd5, 4'b1011);
        check("ands_flags", 32'(bus.Flags), 32'b1010);
        // LDR to PC, STR, branch, never-branch, Op=11, unsupported op to PC
        issue(4'hE, 2'b01, 6'b000001, 4'd15, 4'b0000);
        issue(4'hE, 2'b01, 6'b000000, 4'd1, 4'b0000);
        issue(4'hE, 2'b10, 6'b000000, 4'd0, 4'b0000);
        issue(4'hF, 2'b10, 6'b000000, 4'd0, 4'b0000);
        issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
        issue(4'hE, 2'b00, 6'b010111, 4'd15, 4'b0101);
        check("unsupported_keeps_flags", 32'(bus.Flags), 32'b1010);

        repeat (150) issue_random();

        // make flags nonzero, then reset in the middle of a store
        issue(4'hE, 2'b00, 6'b001001, 4'd1, 4'b1101);
        mon_en = 1'b0;
        bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b000000; bus.Rd = 4'd2;
        reached = 1'b0;
        for (int i = 0; i < 8 && !reached; i++) begin
            @(posedge clk); #1;
            if (bus.State == 4'd5) reached = 1'b1;
        end
        check("reached_memwr", 32'(reached), 32'd1);
        check("memwr_memwrite", 32'(bus.MemWrite), 32'd1);
        check("flags_before_reset", 32'(bus.Flags), 32'b1101);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("async_rst_state", 32'(bus.State), 32'd0);
        check("async_rst_flags", 32'(bus.Flags), 32'd0);
        check("async_rst_enables", 32'({bus.PCWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        @(posedge clk); #1;
        check("held_rst_state", 32'(bus.State), 32'd0);
        check("held_rst_irwrite", 32'(bus.IRWrite), 32'd0);
        rst_n = 1'b1;
        m_flags = 4'b0000;
        mon_en = 1'b1;

        issue(4'hE, 2'b00, 6'b101000, 4'd3, 4'b0000);
        repeat (60) issue_random();

        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
